// File: rtl/acq_sequencer.sv
// Frame acquisition sequencer: a period timer launches multi-bank captures, then a
// complite-edge reader handshake, with sticky timeout/overrun reporting.
module acq_sequencer #(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned TMO_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_enable,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [3:0]          i_ch_mask,
  input  logic [TMO_W-1:0]    i_timeout,
  output logic [3:0]          o_start,
  input  logic [3:0]          i_done,
  output logic                o_complite,
  input  logic                i_rd_busy,
  input  logic                i_clr_err,
  output logic                o_frame_done,
  output logic [15:0]         o_frame_cnt,
  output logic                o_timeout_err,
  output logic                o_overrun
);

  typedef enum logic [1:0] {StIdle, StCapture, StRelease, StDrain} state_e;

  localparam logic [PERIOD_W-1:0] PeriodMin = PERIOD_W'(2);

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic [PERIOD_W-1:0] per_last_q, per_last_d;
  logic [PERIOD_W-1:0] per_eff;
  logic                tick;
  logic [3:0]          pending_q, pending_d, pending_nx;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                rel_q, rel_d;
  logic [3:0]          start_q, start_d;
  logic                complite_q, complite_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                tmo_err_q, tmo_err_d, tmo_set;
  logic                overrun_q, overrun_d, overrun_set;

  // The limit is latched only while the counter sits at 0, so period changes
  // apply from the next reload onward.
  always_comb begin
    per_eff    = (i_period < PeriodMin) ? PeriodMin : i_period;
    per_last_d = (per_cnt_q == '0) ? per_eff - PERIOD_W'(1) : per_last_q;
    tick       = i_enable && (per_cnt_q != '0) && (per_cnt_q == per_last_q);
    if (!i_enable || tick) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = per_cnt_q + PERIOD_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    start_d      = '0;
    complite_d   = complite_q;
    pending_d    = pending_q;
    tmo_d        = tmo_q;
    rel_d        = rel_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    tmo_set      = 1'b0;
    overrun_set  = tick && (state_q != StIdle);
    // Done pulses coinciding with the start pulse are not yet accepted.
    pending_nx   = (start_q != '0) ? pending_q : (pending_q & ~i_done);

    case (state_q)
      StIdle: begin
        complite_d = 1'b0;
        if (tick && (i_ch_mask != '0)) begin
          state_d    = StCapture;
          start_d    = i_ch_mask;
          pending_d  = i_ch_mask;
          tmo_d      = '0;
          complite_d = 1'b1;
        end
      end
      StCapture: begin
        pending_d = pending_nx;
        tmo_d     = (tmo_q == '1) ? tmo_q : tmo_q + TMO_W'(1);
        if (pending_nx == '0) begin
          state_d    = StRelease;
          complite_d = 1'b0;
          rel_d      = 1'b0;
        end else if ((i_timeout != '0) && (tmo_d >= i_timeout)) begin
          state_d    = StRelease;
          complite_d = 1'b0;
          rel_d      = 1'b0;
          tmo_set    = 1'b1;
        end
      end
      StRelease: begin
        complite_d = 1'b0;
        if (rel_q) begin
          state_d = StDrain;
        end else begin
          rel_d = 1'b1;
        end
      end
      StDrain: begin
        complite_d = 1'b0;
        if (!i_rd_busy) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d    = StIdle;
        complite_d = 1'b0;
      end
    endcase

    tmo_err_d = tmo_set | (tmo_err_q & ~i_clr_err);
    overrun_d = overrun_set | (overrun_q & ~i_clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      per_cnt_q    <= '0;
      per_last_q   <= '0;
      pending_q    <= '0;
      tmo_q        <= '0;
      rel_q        <= 1'b0;
      start_q      <= '0;
      complite_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      tmo_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      per_last_q   <= per_last_d;
      pending_q    <= pending_d;
      tmo_q        <= tmo_d;
      rel_q        <= rel_d;
      start_q      <= start_d;
      complite_q   <= complite_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      tmo_err_q    <= tmo_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_start       = start_q;
  assign o_complite    = complite_q;
  assign o_frame_done  = frame_done_q;
  assign o_frame_cnt   = frame_cnt_q;
  assign o_timeout_err = tmo_err_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: per-scenario tasks plus a scoreboard monitor
// comparing start masks and frame counts as the DUT emits them.
module tb_acq_sequencer;
  localparam int PW = 24;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_enable = 1'b0;
  logic [PW-1:0] i_period = 10;
  logic [3:0]    i_ch_mask = '0;
  logic [TW-1:0] i_timeout = '0;
  logic [3:0]    o_start;
  logic [3:0]    i_done = '0;
  logic          o_complite;
  logic          i_rd_busy = 1'b0;
  logic          i_clr_err = 1'b0;
  logic          o_frame_done;
  logic [15:0]   o_frame_cnt;
  logic          o_timeout_err;
  logic          o_overrun;

  acq_sequencer #(.PERIOD_W(PW), .TMO_W(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (i_enable),
    .i_period     (i_period),
    .i_ch_mask    (i_ch_mask),
    .i_timeout    (i_timeout),
    .o_start      (o_start),
    .i_done       (i_done),
    .o_complite   (o_complite),
    .i_rd_busy    (i_rd_busy),
    .i_clr_err    (i_clr_err),
    .o_frame_done (o_frame_done),
    .o_frame_cnt  (o_frame_cnt),
    .o_timeout_err(o_timeout_err),
    .o_overrun    (o_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_seen = 0;
  int done_seen = 0;
  int compl_cycles = 0;
  logic [3:0]  exp_start[$];
  logic [15:0] exp_cnt[$];
  logic [15:0] model_cnt = '0;
  logic [3:0]  mon_start;
  logic [15:0] mon_cnt;

  // Scoreboard monitor: every start pulse and frame_done must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_complite) compl_cycles++;
      if (o_start !== 4'b0) begin
        start_seen++;
        checks++;
        if (exp_start.size() == 0) begin
          errors++;
          $display("FAIL start_pulse: got %b, expected no start", o_start);
        end else begin
          mon_start = exp_start.pop_front();
          if (o_start !== mon_start) begin
            errors++;
            $display("FAIL start_mask: got %b, expected %b", o_start, mon_start);
          end
        end
      end
      if (o_frame_done === 1'b1) begin
        done_seen++;
        checks++;
        if (exp_cnt.size() == 0) begin
          errors++;
          $display("FAIL frame_done: unexpected pulse, frame_cnt %h", o_frame_cnt);
        end else begin
          mon_cnt = exp_cnt.pop_front();
          if (o_frame_cnt !== mon_cnt) begin
            errors++;
            $display("FAIL frame_cnt: got %h, expected %h", o_frame_cnt, mon_cnt);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [3:0] mask);
    exp_start.push_back(mask);
    model_cnt = model_cnt + 16'd1;
    exp_cnt.push_back(model_cnt);
  endtask

  task automatic wait_start(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_start === 4'b0 && n < bound);
    checks++;
    if (o_start === 4'b0) begin
      errors++;
      $display("FAIL wait_start: no o_start within %0d cycles, expected a pulse", bound);
    end
  endtask

  task automatic wait_frame_done(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_frame_done !== 1'b1 && n < bound);
    checks++;
    if (o_frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame_done: no pulse within %0d cycles, expected one", bound);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_start, o_complite, o_frame_done, o_frame_cnt, o_timeout_err, o_overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: start=%b complite=%b fd=%b cnt=%h terr=%b ovr=%b, expected 0",
               o_start, o_complite, o_frame_done, o_frame_cnt, o_timeout_err, o_overrun);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    int base_s;
    int base_d;
    base_s = start_seen;
    base_d = done_seen;
    i_period = 10; i_ch_mask = 4'b0101; i_timeout = '0; i_rd_busy = 1'b1;
    expect_frame(4'b0101);
    i_enable = 1'b1;
    wait_start(40, n);
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL first_tick_latency: got %0d, expected 11", n);
    end
    i_enable = 1'b0;
    step(); i_ch_mask = 4'b1111;         // s+1: mask change must not touch pending
    step(); i_done = 4'b0010;            // s+2: unmasked bank ignored
    step(); i_done = 4'b0001;            // s+3
    step(); i_done = 4'b0000;            // s+4
    @(negedge clk);
    checks++;
    if (o_complite !== 1'b1) begin
      errors++; $display("FAIL complite_s4: got %b, expected 1", o_complite);
    end
    step(); i_done = 4'b0100;            // s+5
    @(negedge clk);
    checks++;
    if (o_complite !== 1'b1) begin
      errors++; $display("FAIL complite_s5: got %b, expected 1", o_complite);
    end
    step(); i_done = 4'b0000;            // s+6
    @(negedge clk);
    checks++;
    if (o_complite !== 1'b0) begin
      errors++; $display("FAIL complite_fall: got %b, expected 0", o_complite);
    end
    repeat (20) step();
    checks++;
    if (done_seen != base_d || o_complite !== 1'b0) begin
      errors++;
      $display("FAIL drain_hold: frame_done count %0d complite %b, expected %0d and 0",
               done_seen, o_complite, base_d);
    end
    i_rd_busy = 1'b0;
    wait_frame_done(10);
    checks++;
    if (start_seen - base_s != 1) begin
      errors++; $display("FAIL basic_start_count: got %0d, expected 1", start_seen - base_s);
    end
    i_ch_mask = 4'b0000;
  endtask

  task automatic test_timeout();
    int n;
    int k;
    step();
    i_period = 6; i_ch_mask = 4'b0001; i_timeout = 8; i_rd_busy = 1'b0;
    expect_frame(4'b0001);
    i_enable = 1'b1;
    wait_start(40, n);
    checks++;
    if (n != 7) begin
      errors++; $display("FAIL period6_latency: got %0d, expected 7", n);
    end
    i_enable = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (o_complite === 1'b1 && k < 30);
    checks++;
    if (k != 8) begin
      errors++; $display("FAIL timeout_fall: complite fell after %0d cycles, expected 8", k);
    end
    checks++;
    if (o_timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_err_set: got %b, expected 1", o_timeout_err);
    end
    wait_frame_done(20);
    step();
    checks++;
    if (o_timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_err_sticky: got %b, expected 1", o_timeout_err);
    end
    i_clr_err = 1'b1;
    step();
    i_clr_err = 1'b0;
    @(negedge clk);
    checks++;
    if (o_timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_err_clear: got %b, expected 0", o_timeout_err);
    end
    i_timeout = '0;
  endtask

  task automatic test_back_to_back();
    int n;
    int base_s;
    int base_d;
    step();
    base_s = start_seen;
    base_d = done_seen;
    i_period = 4; i_ch_mask = 4'b0011; i_rd_busy = 1'b1;
    expect_frame(4'b0011);
    i_enable = 1'b1;
    wait_start(20, n);
    step(); i_done = 4'b0011;
    step(); i_done = 4'b0000;
    repeat (30) step();
    i_enable = 1'b0;
    step();
    checks++;
    if (o_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_set: got %b, expected 1", o_overrun);
    end
    i_rd_busy = 1'b0;
    wait_frame_done(10);
    repeat (10) step();
    checks++;
    if (start_seen - base_s != 1 || done_seen - base_d != 1) begin
      errors++;
      $display("FAIL overrun_single_frame: starts %0d frames %0d, expected 1 and 1",
               start_seen - base_s, done_seen - base_d);
    end
    i_clr_err = 1'b1;
    step();
    i_clr_err = 1'b0;
    @(negedge clk);
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_clear: got %b, expected 0", o_overrun);
    end
  endtask

  task automatic test_mask_zero();
    int base_s;
    int base_c;
    step();
    base_s = start_seen;
    base_c = compl_cycles;
    i_period = 4; i_ch_mask = 4'b0000;
    i_enable = 1'b1;
    repeat (22) step();
    i_enable = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (start_seen != base_s || compl_cycles != base_c || o_frame_cnt !== model_cnt ||
        o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL mask_zero: starts %0d complite %0d cnt %h ovr %b, expected %0d %0d %h 0",
               start_seen, compl_cycles, o_frame_cnt, o_overrun, base_s, base_c, model_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    step();
    i_period = 5; i_ch_mask = 4'b0001; i_rd_busy = 1'b0;
    expect_frame(4'b0001);
    i_enable = 1'b1;
    wait_start(20, n);
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_start, o_complite, o_frame_done, o_timeout_err, o_overrun} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: start=%b complite=%b fd=%b terr=%b ovr=%b, expected 0",
               o_start, o_complite, o_frame_done, o_timeout_err, o_overrun);
    end
    checks++;
    if (o_frame_cnt !== 16'h0000) begin
      errors++; $display("FAIL reset_mid_cnt: got %h, expected 0000", o_frame_cnt);
    end
    void'(exp_cnt.pop_back());
    model_cnt = '0;
    i_enable = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    expect_frame(4'b0001);
    i_enable = 1'b1;
    wait_start(20, n);
    checks++;
    if (n != 6) begin
      errors++; $display("FAIL post_reset_tick: got %0d, expected 6", n);
    end
    i_enable = 1'b0;
    step(); i_done = 4'b0001;
    step(); i_done = 4'b0000;
    wait_frame_done(20);
  endtask

  task automatic test_wrap();
    int n;
    step();
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    model_cnt = 16'hFFFF;
    checks++;
    if (o_frame_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: got %h, expected ffff", o_frame_cnt);
    end
    step();
    i_period = 3; i_ch_mask = 4'b1000; i_rd_busy = 1'b0;
    expect_frame(4'b1000);
    i_enable = 1'b1;
    wait_start(20, n);
    i_enable = 1'b0;
    step(); i_done = 4'b1000;
    step(); i_done = 4'b0000;
    wait_frame_done(20);
    step();
    checks++;
    if (o_frame_cnt !== 16'h0000) begin
      errors++; $display("FAIL wrap_value: got %h, expected 0000", o_frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_back_to_back();
    test_mask_zero();
    test_reset_mid();
    test_wrap();
    repeat (5) step();
    checks++;
    if (exp_start.size() != 0 || exp_cnt.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d starts and %0d frames outstanding, expected 0 and 0",
               exp_start.size(), exp_cnt.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
